fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter that shares one synchronous-FIFO write port among
// NUM_REQ producers. It locks the grant for a packet, never writes into a full FIFO, and
// tracks write responses.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_wr_en,
  output logic [FIFO_WIDTH-1:0]         o_data_in,
  input  logic                          i_full,
  input  logic                          i_wr_ack,
  input  logic                          i_overflow,
  input  logic                          i_err_clr,
  output logic                          o_busy,
  output logic [IDX_W-1:0]              o_owner,
  output logic                          o_ack_err,
  output logic                          o_ovf_err,
  output logic                          o_burst_err,
  output logic [15:0]                   o_wr_count
);

  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
  localparam int unsigned WCNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    w_rr_ptr_nxt;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    w_owner_nxt;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [CNT_W-1:0]    w_beat_cnt_nxt;
  logic                r_busy;
  logic                r_pend;
  logic                r_ack_err;
  logic                w_ack_err_nxt;
  logic                r_ovf_err;
  logic                w_ovf_err_nxt;
  logic                r_burst_err;
  logic                w_burst_err_nxt;
  logic                w_burst_set;
  logic [WCNT_W-1:0]   r_wr_count;
  logic [WCNT_W-1:0]   w_wr_count_nxt;

  logic                w_found;
  logic [IDX_W-1:0]    w_winner;
  logic [IDX_W-1:0]    w_cand;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_grant_act;
  logic                w_last;
  logic [FIFO_WIDTH-1:0] w_sel_data;

  // Wrapping increment of a requester index
  function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Round-robin search starting at rr_ptr
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && i_req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Grant, ready and the zero-latency write path
  always_comb begin
    w_grant_idx = (r_state == ST_LOCK) ? r_owner : w_winner;
    w_grant_act = (r_state == ST_LOCK) || w_found;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_sel_data = i_req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
    o_req_ready = '0;
    if (rst_n && w_grant_act && !i_full) begin
      o_req_ready[w_grant_idx] = 1'b1;
    end
    o_wr_en   = |(i_req_valid & o_req_ready);
    o_data_in = o_wr_en ? w_sel_data : '0;
    w_last    = i_req_last[w_grant_idx];
  end

  // Next-state logic; only an accepted beat moves the FSM, so full freezes everything
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    w_burst_set    = 1'b0;
    if (o_wr_en) begin
      case (r_state)
        ST_IDLE: begin
          w_owner_nxt = w_grant_idx;
          if (w_last) begin
            w_rr_ptr_nxt = f_inc(w_grant_idx);
          end else begin
            w_state_nxt    = ST_LOCK;
            w_beat_cnt_nxt = CNT_W'(1);
          end
        end
        ST_LOCK: begin
          if (w_last) begin
            w_state_nxt    = ST_IDLE;
            w_rr_ptr_nxt   = f_inc(r_owner);
            w_beat_cnt_nxt = '0;
          end else if ((32'(r_beat_cnt) + 32'd1) >= MAX_BURST) begin
            // Over-long packet: drop the lock and let the remainder re-arbitrate
            w_state_nxt    = ST_IDLE;
            w_rr_ptr_nxt   = f_inc(r_owner);
            w_beat_cnt_nxt = '0;
            w_burst_set    = 1'b1;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Response checking; a same-cycle set beats err_clr
  always_comb begin
    w_ack_err_nxt   = (r_pend && !i_wr_ack) ? 1'b1 : (i_err_clr ? 1'b0 : r_ack_err);
    w_ovf_err_nxt   = i_overflow            ? 1'b1 : (i_err_clr ? 1'b0 : r_ovf_err);
    w_burst_err_nxt = w_burst_set           ? 1'b1 : (i_err_clr ? 1'b0 : r_burst_err);
    w_wr_count_nxt  = i_wr_ack ? r_wr_count + WCNT_W'(1) : r_wr_count;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_beat_cnt  <= '0;
      r_busy      <= 1'b0;
      r_pend      <= 1'b0;
      r_ack_err   <= 1'b0;
      r_ovf_err   <= 1'b0;
      r_burst_err <= 1'b0;
      r_wr_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_busy      <= (w_state_nxt == ST_LOCK);
      r_pend      <= o_wr_en;
      r_ack_err   <= w_ack_err_nxt;
      r_ovf_err   <= w_ovf_err_nxt;
      r_burst_err <= w_burst_err_nxt;
      r_wr_count  <= w_wr_count_nxt;
    end
  end

  assign o_busy      = r_busy;
  assign o_owner     = r_owner;
  assign o_ack_err   = r_ack_err;
  assign o_ovf_err   = r_ovf_err;
  assign o_burst_err = r_burst_err;
  assign o_wr_count  = r_wr_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a behavioural arbiter/FIFO-response model is checked
// against the DUT every cycle, and literal expectations pin down key scenarios.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned FW = 16;
  localparam int unsigned MB = 8;
  localparam int unsigned IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     i_req_valid;
  logic [NR-1:0]     i_req_last;
  logic [NR*FW-1:0]  i_req_data;
  logic [NR-1:0]     o_req_ready;
  logic              o_wr_en;
  logic [FW-1:0]     o_data_in;
  logic              i_full;
  logic              i_wr_ack;
  logic              i_overflow;
  logic              i_err_clr;
  logic              o_busy;
  logic [IW-1:0]     o_owner;
  logic              o_ack_err;
  logic              o_ovf_err;
  logic              o_burst_err;
  logic [15:0]       o_wr_count;

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .FIFO_WIDTH(FW), .MAX_BURST(MB), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_last(i_req_last), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_wr_en(o_wr_en), .o_data_in(o_data_in),
    .i_full(i_full), .i_wr_ack(i_wr_ack), .i_overflow(i_overflow), .i_err_clr(i_err_clr),
    .o_busy(o_busy), .o_owner(o_owner), .o_ack_err(o_ack_err), .o_ovf_err(o_ovf_err),
    .o_burst_err(o_burst_err), .o_wr_count(o_wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int seq   = 0;
  bit withhold = 1'b0;
  logic [FW-1:0] tb_data [NR];

  // Behavioural model state
  bit m_locked, m_pend, m_ack_err, m_ovf_err, m_burst_err;
  int m_owner, m_rr, m_beats, m_count;
  logic [NR-1:0] e_ready;
  bit e_wr;
  int e_g;
  logic [FW-1:0] e_data;

  // Samples taken at the compare point of the last cycle
  logic [NR-1:0] s_ready;
  logic          s_wr;
  logic          s_busy;
  logic [IW-1:0] s_owner;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i] === 1'b1 && r < 0) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_pend = 0; m_ack_err = 0; m_ovf_err = 0; m_burst_err = 0;
    m_owner = 0; m_rr = 0; m_beats = 0; m_count = 0;
  endtask

  task automatic model_comb();
    e_ready = '0;
    e_g = -1;
    if (rst_n) begin
      if (m_locked) e_g = m_owner;
      else begin
        for (int k = 0; k < NR; k++) begin
          int j = (m_rr + k) % NR;
          if (e_g < 0 && i_req_valid[j]) e_g = j;
        end
      end
      if (e_g >= 0 && !i_full) e_ready[e_g] = 1'b1;
    end
    e_wr   = (e_g >= 0) && e_ready[e_g] && i_req_valid[e_g];
    e_data = e_wr ? tb_data[e_g] : '0;
  endtask

  task automatic model_seq();
    bit burst_set = 0;
    bit last;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (e_wr) begin
      last = i_req_last[e_g];
      if (!m_locked) begin
        m_owner = e_g;
        if (last) m_rr = (e_g + 1) % NR;
        else begin m_locked = 1; m_beats = 1; end
      end else if (last) begin
        m_locked = 0; m_rr = (m_owner + 1) % NR; m_beats = 0;
      end else if (m_beats + 1 == MB) begin
        m_locked = 0; m_rr = (m_owner + 1) % NR; m_beats = 0; burst_set = 1;
      end else begin
        m_beats++;
      end
    end
    m_ack_err   = (m_pend && !i_wr_ack) || (m_ack_err && !i_err_clr);
    m_ovf_err   = i_overflow || (m_ovf_err && !i_err_clr);
    m_burst_err = burst_set || (m_burst_err && !i_err_clr);
    if (i_wr_ack) m_count = (m_count + 1) % 65536;
    m_pend = e_wr;
  endtask

  // One clock: drive data, compare at negedge, advance model at posedge, play FIFO response
  task automatic cycle();
    bit ack_next;
    for (int i = 0; i < NR; i++) begin
      tb_data[i] = 16'(((i + 1) << 12) | (seq & 12'hFFF));
      i_req_data[i*FW +: FW] = tb_data[i];
    end
    seq++;
    @(negedge clk);
    model_comb();
    s_ready = o_req_ready; s_wr = o_wr_en; s_busy = o_busy; s_owner = o_owner;
    chk("req_ready", 32'(o_req_ready), 32'(e_ready));
    chk("wr_en", 32'(o_wr_en), 32'(e_wr));
    chk("data_in", 32'(o_data_in), 32'(e_data));
    chk("busy", 32'(o_busy), 32'(m_locked));
    chk("owner", 32'(o_owner), 32'(m_owner));
    chk("ack_err", 32'(o_ack_err), 32'(m_ack_err));
    chk("ovf_err", 32'(o_ovf_err), 32'(m_ovf_err));
    chk("burst_err", 32'(o_burst_err), 32'(m_burst_err));
    chk("wr_count", 32'(o_wr_count), 32'(m_count));
    @(posedge clk);
    model_seq();
    ack_next = e_wr && !withhold;
    withhold = 1'b0;
    #1;
    i_wr_ack   = ack_next;
    i_overflow = 1'b0;
    i_err_clr  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_order [6] = '{0, 1, 3, 0, 1, 3};
    rst_n = 1'b0; i_req_valid = '0; i_req_last = '0; i_req_data = '0;
    i_full = 1'b0; i_wr_ack = 1'b0; i_overflow = 1'b0; i_err_clr = 1'b0;
    @(posedge clk); #1;
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_owner", 32'(o_owner), 32'd0);
    chk("rst_count", 32'(o_wr_count), 32'd0);

    // Round robin over 0,1,3 with single-beat packets
    i_req_valid = 4'b1011; i_req_last = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_grant", 32'(onehot_idx(s_ready)), 32'(exp_order[i]));
      chk("rr_wr_en", 32'(s_wr), 32'd1);
    end
    i_req_valid = '0;
    repeat (2) cycle();
    chk("rr_count6", 32'(o_wr_count), 32'd6);

    // Three-beat packet from req1 while req0 waits
    i_req_valid = 4'b0001; i_req_last = 4'b0001;
    cycle();
    i_req_valid = 4'b0011; i_req_last = 4'b0001;
    cycle();
    chk("pkt_b1_ready", 32'(s_ready), 32'b0010);
    chk("pkt_b1_busy", 32'(s_busy), 32'd0);
    cycle();
    chk("pkt_b2_ready", 32'(s_ready), 32'b0010);
    chk("pkt_b2_busy", 32'(s_busy), 32'd1);
    i_req_last = 4'b0011;
    cycle();
    chk("pkt_b3_ready", 32'(s_ready), 32'b0010);
    chk("pkt_b3_busy", 32'(s_busy), 32'd1);
    cycle();
    chk("pkt_next_ready", 32'(s_ready), 32'b0001);
    chk("pkt_next_busy", 32'(s_busy), 32'd0);

    // FIFO full during a lock owned by req1
    i_req_valid = 4'b0010; i_req_last = 4'b0000;
    cycle();
    i_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("full_ready", 32'(s_ready), 32'd0);
      chk("full_wr_en", 32'(s_wr), 32'd0);
      chk("full_busy", 32'(s_busy), 32'd1);
    end
    i_full = 1'b0;
    cycle();
    chk("full_resume_ready", 32'(s_ready), 32'b0010);
    chk("full_resume_owner", 32'(s_owner), 32'd1);
    i_req_last = 4'b0010;
    cycle();
    i_req_valid = '0;
    cycle();
    chk("full_no_ovf", 32'(o_ovf_err), 32'd0);

    // Over-long packet from req2 hits MAX_BURST
    i_req_valid = 4'b0100; i_req_last = 4'b0000;
    repeat (MB) cycle();
    chk("burst_ready", 32'(s_ready), 32'b0100);
    chk("burst_idle", 32'(o_busy), 32'd0);
    chk("burst_err_set", 32'(o_burst_err), 32'd1);
    i_req_valid = 4'b1101; i_req_last = 4'b1101;
    cycle();
    chk("burst_rr3", 32'(onehot_idx(s_ready)), 32'd3);
    i_req_valid = 4'b0100; i_req_last = 4'b0000;
    repeat (2) cycle();
    chk("burst_relock", 32'(o_busy), 32'd1);
    i_req_last = 4'b0100;
    cycle();
    i_req_valid = '0; i_err_clr = 1'b1;
    cycle();
    chk("burst_err_clr", 32'(o_burst_err), 32'd0);

    // Missing wr_ack and overflow, sticky until cleared
    i_req_valid = 4'b0001; i_req_last = 4'b0001; withhold = 1'b1;
    cycle();
    i_req_valid = '0;
    cycle();
    chk("ack_err_set", 32'(o_ack_err), 32'd1);
    i_overflow = 1'b1;
    cycle();
    chk("ovf_err_set", 32'(o_ovf_err), 32'd1);
    repeat (3) cycle();
    chk("ack_err_hold", 32'(o_ack_err), 32'd1);
    chk("ovf_err_hold", 32'(o_ovf_err), 32'd1);
    i_overflow = 1'b1; i_err_clr = 1'b1;
    cycle();
    chk("ovf_set_wins", 32'(o_ovf_err), 32'd1);
    chk("ack_err_clr", 32'(o_ack_err), 32'd0);
    i_err_clr = 1'b1;
    cycle();
    chk("ovf_err_clr", 32'(o_ovf_err), 32'd0);

    // Reset in the middle of a lock owned by req2
    i_req_valid = 4'b0100; i_req_last = 4'b0000;
    repeat (3) cycle();
    chk("prerst_busy", 32'(o_busy), 32'd1);
    chk("prerst_owner", 32'(o_owner), 32'd2);
    rst_n = 1'b0;
    cycle();
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_wr_en", 32'(s_wr), 32'd0);
    chk("rst2_busy", 32'(o_busy), 32'd0);
    chk("rst2_owner", 32'(o_owner), 32'd0);
    chk("rst2_count", 32'(o_wr_count), 32'd0);
    chk("rst2_flags", 32'({o_ack_err, o_ovf_err, o_burst_err}), 32'd0);
    rst_n = 1'b1; i_req_valid = '0;
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
